// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory arbiter and its write-back buffer.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_LINE_W = 128;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_WB   = 2'd1;
  localparam owner_t OWN_D    = 2'd2;
  localparam owner_t OWN_I    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/wb_line_buffer.sv
// One-entry dirty-line buffer: captures a write-back when empty, freed on write completion.
module wb_line_buffer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wline,
  input  logic              free,
  output logic              ready,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [LINE_W-1:0] buf_line
);

  // A pulse while full is a protocol error and must not clobber the held line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready    <= 1'b1;
      buf_addr <= '0;
      buf_line <= '0;
    end else if (we && ready) begin
      ready    <= 1'b0;
      buf_addr <= addr;
      buf_line <= wline;
    end else if (free) begin
      ready    <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pulse-request line memory between I-refill, D-refill and D write-back,
// with write-back-first ordering and an I-side starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned LINE_W       = DEF_LINE_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ic_mem_req,
  input  logic [ADDR_W-1:0] Ic_mem_addr,
  output logic [LINE_W-1:0] F_mem_inst,
  output logic              F_mem_valid,
  input  logic              Dc_mem_req,
  input  logic [ADDR_W-1:0] Dc_mem_addr,
  output logic [LINE_W-1:0] MEM_data_line,
  output logic              MEM_mem_valid,
  input  logic              Dc_wb_we,
  input  logic [ADDR_W-1:0] Dc_wb_addr,
  input  logic [LINE_W-1:0] Dc_wb_wline,
  output logic              Dc_wb_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wline,
  input  logic [LINE_W-1:0] mem_rline,
  input  logic              mem_valid,
  output logic [1:0]        arb_owner
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_line;
  logic              wb_free_c;
  logic              starve_hit_c;
  owner_t            grant_c;

  assign wb_free_c    = (state == WAIT) && mem_valid && (arb_owner == OWN_WB);
  assign starve_hit_c = (starve_cnt == CNT_W'(STARVE_LIMIT));

  wb_line_buffer #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_wb_buf (
    .clk      (clk),
    .rst      (rst),
    .we       (Dc_wb_we),
    .addr     (Dc_wb_addr),
    .wline    (Dc_wb_wline),
    .free     (wb_free_c),
    .ready    (Dc_wb_ready),
    .buf_addr (wb_addr),
    .buf_line (wb_line)
  );

  // Fixed priority WB > D > I, except a starved I-side overtakes D (never WB).
  always_comb begin
    grant_c = OWN_NONE;
    if (!Dc_wb_ready)                    grant_c = OWN_WB;
    else if (Ic_mem_req && starve_hit_c) grant_c = OWN_I;
    else if (Dc_mem_req)                 grant_c = OWN_D;
    else if (Ic_mem_req)                 grant_c = OWN_I;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      arb_owner     <= OWN_NONE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wline     <= '0;
      F_mem_inst    <= '0;
      F_mem_valid   <= 1'b0;
      MEM_data_line <= '0;
      MEM_mem_valid <= 1'b0;
    end else begin
      F_mem_valid   <= 1'b0;
      MEM_mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!Ic_mem_req || grant_c == OWN_I) begin
            starve_cnt <= '0;
          end else if (grant_c != OWN_NONE && !starve_hit_c) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
          if (grant_c != OWN_NONE) begin
            arb_owner <= grant_c;
            state     <= ISSUE;
            mem_req   <= 1'b1;
            mem_we    <= (grant_c == OWN_WB);
            if (grant_c == OWN_WB) begin
              mem_addr  <= wb_addr;
              mem_wline <= wb_line;
            end else if (grant_c == OWN_D) begin
              mem_addr  <= Dc_mem_addr;
            end else begin
              mem_addr  <= Ic_mem_addr;
            end
          end
        end
        ISSUE: begin
          mem_req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (mem_valid) begin
            if (arb_owner == OWN_I) begin
              F_mem_inst  <= mem_rline;
              F_mem_valid <= 1'b1;
            end else if (arb_owner == OWN_D) begin
              MEM_data_line <= mem_rline;
              MEM_mem_valid <= 1'b1;
            end
            state <= RECOVER;
          end
        end
        RECOVER: begin
          arb_owner <= OWN_NONE;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model answers requests, a monitor checks every pulse.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [127:0] L12   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] L100  = 128'h1000_2000_3000_4000_5000_6000_7000_8000;
  localparam logic [127:0] L200  = 128'hDEAD_BEEF_0200_0200_CAFE_F00D_0200_0200;
  localparam logic [127:0] LA5   = {16{8'hA5}};
  localparam logic [127:0] L1111 = {8{16'h1111}};
  localparam logic [127:0] L2222 = {8{16'h2222}};

  typedef struct packed {
    logic         we;
    logic [15:0]  addr;
    logic [127:0] wline;
    logic [1:0]   owner;
  } exp_req_t;

  logic         clk, rst;
  logic         Ic_mem_req, Dc_mem_req, Dc_wb_we;
  logic [15:0]  Ic_mem_addr, Dc_mem_addr, Dc_wb_addr;
  logic [127:0] Dc_wb_wline;
  logic [127:0] F_mem_inst, MEM_data_line;
  logic         F_mem_valid, MEM_mem_valid, Dc_wb_ready;
  logic         mem_req, mem_we, mem_valid;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wline, mem_rline;
  logic [1:0]   arb_owner;

  int checks = 0;
  int fails  = 0;
  int f_seen = 0;
  int d_seen = 0;
  logic stray_valid = 1'b0;

  exp_req_t     exp_req[$];
  logic [127:0] exp_f[$];
  logic [127:0] exp_d[$];
  logic [127:0] mem [logic [15:0]];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .Ic_mem_req(Ic_mem_req), .Ic_mem_addr(Ic_mem_addr),
    .F_mem_inst(F_mem_inst), .F_mem_valid(F_mem_valid),
    .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
    .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_we(Dc_wb_we), .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline),
    .Dc_wb_ready(Dc_wb_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
    .mem_rline(mem_rline), .mem_valid(mem_valid),
    .arb_owner(arb_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input bit ok,
                              input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic bit pick(input int sel);
    case (sel)
      0:       return F_mem_valid;
      1:       return MEM_mem_valid;
      2:       return mem_req;
      default: return mem_valid;
    endcase
  endfunction

  // Returns at the first falling edge where the selected signal is high.
  task automatic wait_pulse(input int sel, input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = pick(sel);
    end
    if (!seen) chk({name, "_timeout"}, 1'b0, 128'(0), 128'(1));
  endtask

  task automatic req_d(input logic [15:0] a);
    Dc_mem_addr = a;
    Dc_mem_req  = 1'b1;
    wait_pulse(1, 100, "d_refill");
    Dc_mem_req  = 1'b0;
  endtask

  task automatic req_i(input logic [15:0] a);
    Ic_mem_addr = a;
    Ic_mem_req  = 1'b1;
    wait_pulse(0, 100, "i_refill");
    Ic_mem_req  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_mem_req"},   mem_req == 1'b0,       128'(mem_req),       128'(0));
    chk({tag, "_mem_we"},    mem_we == 1'b0,        128'(mem_we),        128'(0));
    chk({tag, "_mem_addr"},  mem_addr == 16'h0,     128'(mem_addr),      128'(0));
    chk({tag, "_mem_wline"}, mem_wline == '0,       mem_wline,           128'(0));
    chk({tag, "_f_valid"},   F_mem_valid == 1'b0,   128'(F_mem_valid),   128'(0));
    chk({tag, "_d_valid"},   MEM_mem_valid == 1'b0, 128'(MEM_mem_valid), 128'(0));
    chk({tag, "_f_inst"},    F_mem_inst == '0,      F_mem_inst,          128'(0));
    chk({tag, "_d_line"},    MEM_data_line == '0,   MEM_data_line,       128'(0));
    chk({tag, "_owner"},     arb_owner == OWN_NONE, 128'(arb_owner),     128'(0));
    chk({tag, "_wb_ready"},  Dc_wb_ready == 1'b1,   128'(Dc_wb_ready),   128'(1));
  endtask

  // Memory model: fixed 3-cycle latency, one outstanding access, aborted by reset.
  initial begin
    bit           busy;
    int           cnt;
    logic         p_we;
    logic [15:0]  p_addr;
    logic [127:0] p_wline;
    busy = 1'b0; cnt = 0; p_we = 1'b0; p_addr = '0; p_wline = '0;
    mem[16'h0012] = L12;
    mem[16'h0100] = L100;
    mem[16'h0200] = L200;
    mem_valid = 1'b0;
    mem_rline = '0;
    forever begin
      @(posedge clk); #1;
      mem_valid = stray_valid;
      if (!rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy      = 1'b0;
            mem_valid = 1'b1;
            if (p_we) mem[p_addr] = p_wline;
            else      mem_rline = mem.exists(p_addr) ? mem[p_addr] : '0;
          end
        end
        if (mem_req) begin
          busy = 1'b1; cnt = 3;
          p_we = mem_we; p_addr = mem_addr; p_wline = mem_wline;
        end
      end
    end
  end

  // Scoreboard monitor: every memory request and every cache response pops its expectation.
  initial begin
    exp_req_t     e;
    logic [127:0] l;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        if (mem_req) begin
          if (exp_req.size() == 0) begin
            chk("unexpected_mem_req", 1'b0, 128'(mem_addr), 128'(0));
          end else begin
            e = exp_req.pop_front();
            chk("req_we",    mem_we == e.we,       128'(mem_we),    128'(e.we));
            chk("req_addr",  mem_addr == e.addr,   128'(mem_addr),  128'(e.addr));
            chk("req_owner", arb_owner == e.owner, 128'(arb_owner), 128'(e.owner));
            if (e.we) chk("req_wline", mem_wline == e.wline, mem_wline, e.wline);
          end
        end
        if (F_mem_valid) begin
          f_seen++;
          if (exp_f.size() == 0) chk("unexpected_f_valid", 1'b0, F_mem_inst, 128'(0));
          else begin
            l = exp_f.pop_front();
            chk("f_inst", F_mem_inst == l, F_mem_inst, l);
          end
        end
        if (MEM_mem_valid) begin
          d_seen++;
          if (exp_d.size() == 0) chk("unexpected_d_valid", 1'b0, MEM_data_line, 128'(0));
          else begin
            l = exp_d.pop_front();
            chk("d_line", MEM_data_line == l, MEM_data_line, l);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    rst = 1'b0;
    Ic_mem_req = 1'b0; Ic_mem_addr = '0;
    Dc_mem_req = 1'b0; Dc_mem_addr = '0;
    Dc_wb_we = 1'b0; Dc_wb_addr = '0; Dc_wb_wline = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single I refill: latency checks around the memory handshake.
    exp_req.push_back('{1'b0, 16'h0012, 128'(0), OWN_I});
    exp_f.push_back(L12);
    Ic_mem_addr = 16'h0012;
    Ic_mem_req  = 1'b1;
    @(negedge clk);
    chk("i_req_latency", mem_req == 1'b1, 128'(mem_req), 128'(1));
    chk("i_req_addr", mem_addr == 16'h0012, 128'(mem_addr), 128'(16'h0012));
    wait_pulse(3, 20, "i_mem_valid");
    @(negedge clk);
    chk("f_valid_latency", F_mem_valid == 1'b1, 128'(F_mem_valid), 128'(1));
    chk("d_valid_quiet", MEM_mem_valid == 1'b0, 128'(MEM_mem_valid), 128'(0));
    Ic_mem_req = 1'b0;
    repeat (3) @(negedge clk);

    // Simultaneous D and I refills: D first, I after recovery.
    exp_req.push_back('{1'b0, 16'h0100, 128'(0), OWN_D});
    exp_req.push_back('{1'b0, 16'h0200, 128'(0), OWN_I});
    exp_d.push_back(L100);
    exp_f.push_back(L200);
    fork
      req_d(16'h0100);
      req_i(16'h0200);
    join
    repeat (3) @(negedge clk);

    // Write-back then refill of the same line: write issues first, read returns it.
    exp_req.push_back('{1'b1, 16'h0040, LA5, OWN_WB});
    exp_req.push_back('{1'b0, 16'h0040, 128'(0), OWN_D});
    exp_d.push_back(LA5);
    Dc_wb_addr = 16'h0040; Dc_wb_wline = LA5; Dc_wb_we = 1'b1;
    @(negedge clk);
    Dc_wb_we = 1'b0;
    chk("wb_ready_low", Dc_wb_ready == 1'b0, 128'(Dc_wb_ready), 128'(0));
    fork
      req_d(16'h0040);
      begin
        bit seen, bad;
        seen = 1'b0; bad = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (Dc_wb_ready) bad = 1'b1;
          seen = mem_valid && mem_we;
        end
        chk("wb_ready_held_low", seen && !bad, 128'({seen, bad}), 128'(2'b10));
        @(negedge clk);
        chk("wb_ready_freed", Dc_wb_ready == 1'b1, 128'(Dc_wb_ready), 128'(1));
      end
    join
    chk("f_line_held", F_mem_inst == L200, F_mem_inst, L200);
    repeat (3) @(negedge clk);

    // Starvation: four D grants while I waits, fifth grant goes to I.
    for (int i = 0; i < 4; i++) exp_req.push_back('{1'b0, 16'h0100, 128'(0), OWN_D});
    exp_req.push_back('{1'b0, 16'h0200, 128'(0), OWN_I});
    exp_req.push_back('{1'b0, 16'h0100, 128'(0), OWN_D});
    for (int i = 0; i < 5; i++) exp_d.push_back(L100);
    exp_f.push_back(L200);
    base = d_seen;
    Ic_mem_addr = 16'h0200; Ic_mem_req = 1'b1;
    Dc_mem_addr = 16'h0100; Dc_mem_req = 1'b1;
    wait_pulse(0, 200, "starve_i");
    Ic_mem_req = 1'b0;
    for (int i = 0; i < 100 && d_seen < base + 5; i++) @(negedge clk);
    Dc_mem_req = 1'b0;
    chk("starve_d_count", d_seen == base + 5, 128'(d_seen - base), 128'(5));
    repeat (4) @(negedge clk);

    // Protocol error: second write-back pulse while full is dropped.
    exp_req.push_back('{1'b1, 16'h0050, L1111, OWN_WB});
    Dc_wb_addr = 16'h0050; Dc_wb_wline = L1111; Dc_wb_we = 1'b1;
    @(negedge clk);
    chk("wb_full_before_2nd", Dc_wb_ready == 1'b0, 128'(Dc_wb_ready), 128'(0));
    Dc_wb_addr = 16'h0060; Dc_wb_wline = L2222;
    @(negedge clk);
    Dc_wb_we = 1'b0;
    wait_pulse(3, 20, "wb_err_valid");
    repeat (8) @(negedge clk);
    chk("no_second_write", exp_req.size() == 0, 128'(exp_req.size()), 128'(0));
    chk("wb_ready_after_err", Dc_wb_ready == 1'b1, 128'(Dc_wb_ready), 128'(1));

    // Reset in WAIT abandons the I refill; a stale completion is ignored.
    base = f_seen;
    exp_req.push_back('{1'b0, 16'h0012, 128'(0), OWN_I});
    Ic_mem_addr = 16'h0012; Ic_mem_req = 1'b1;
    wait_pulse(2, 20, "rst_issue");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("mid");
    Ic_mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_stray_f_valid", f_seen == base, 128'(f_seen - base), 128'(0));
    chk("idle_after_stray", arb_owner == OWN_NONE, 128'(arb_owner), 128'(0));

    chk("queues_drained", exp_req.size() + exp_f.size() + exp_d.size() == 0,
        128'(exp_req.size() + exp_f.size() + exp_d.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer and arbiter that shares one single-ported line memory between three requesters:
  - I-cache line refills.
  - D-cache line refills.
  - D-cache dirty-line write-backs.
- Sits between icache/dcache and the backing memory, which has a pulse request and a pulse completion.
- Provides a one-entry write-back buffer, fixed priority with an I-side starvation guard, and response routing to the owning cache.

Parameters:
- ADDR_W, 16, line address width (PC_BITS-4).
- LINE_W, 128, cache line width in bits.
- STARVE_LIMIT, 4, consecutive D-side grants allowed while an I-side request waits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (0 = reset)
- Ic_mem_req  in  1  I-cache refill request, level, held until F_mem_valid
- Ic_mem_addr  in  ADDR_W  I-cache refill line address
- F_mem_inst  out  LINE_W  refill line to I-cache
- F_mem_valid  out  1  one-cycle pulse, I refill complete
- Dc_mem_req  in  1  D-cache refill request, level, held until MEM_mem_valid
- Dc_mem_addr  in  ADDR_W  D-cache refill line address
- MEM_data_line  out  LINE_W  refill line to D-cache
- MEM_mem_valid  out  1  one-cycle pulse, D refill complete
- Dc_wb_we  in  1  write-back pulse; legal only when Dc_wb_ready=1
- Dc_wb_addr  in  ADDR_W  write-back line address
- Dc_wb_wline  in  LINE_W  write-back line data
- Dc_wb_ready  out  1  write-back buffer empty
- mem_req  out  1  one-cycle pulse to memory
- mem_we  out  1  qualifies mem_req as a write
- mem_addr  out  ADDR_W  memory line address
- mem_wline  out  LINE_W  write data
- mem_rline  in  LINE_W  read data, valid with mem_valid
- mem_valid  in  1  one-cycle completion pulse (reads and writes)
- arb_owner  out  2  current owner: 0 none, 1 WB, 2 D-refill, 3 I-refill

Behaviour:
- Reset (rst=0, async) clears the FSM, buffer and counters to these values:
  - FSM to IDLE.
  - Write-back buffer empty, so Dc_wb_ready=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wline=0.
  - F_mem_valid=0, MEM_mem_valid=0.
  - F_mem_inst=0, MEM_data_line=0.
  - arb_owner=0, starve counter=0.
- Write-back buffer:
  - A Dc_wb_we pulse while Dc_wb_ready=1 captures addr and line, and Dc_wb_ready drops the next cycle.
  - Dc_wb_we while Dc_wb_ready=0 is a protocol error: it is ignored and the buffer is not overwritten.
  - The buffer is freed in the cycle the write's mem_valid arrives, so Dc_wb_ready=1 the next cycle.
- FSM states are IDLE, ISSUE, WAIT, RECOVER.
- IDLE: choose the owner using these rules.
  - Default priority is WB buffer full > Dc_mem_req > Ic_mem_req.
  - If Ic_mem_req=1 and the starve counter equals STARVE_LIMIT, I-refill wins over D-refill but not over WB.
  - If nothing is pending, stay in IDLE with arb_owner=0.
  - Otherwise latch the owner and go to ISSUE.
  - Requests and write-back pulses arriving in the same cycle: the pulse is only captured that cycle, so it competes from the next IDLE evaluation.
- ISSUE: drive these outputs for exactly one cycle, then go to WAIT.
  - mem_req=1.
  - mem_we=1 for WB, otherwise 0.
  - mem_addr and mem_wline from the owner's source (registered outputs).
- WAIT:
  - Hold mem_addr, mem_we and mem_wline stable and keep mem_req=0.
  - On mem_valid, route the response to the owner:
    - I-refill: F_mem_inst<=mem_rline, F_mem_valid=1 next cycle.
    - D-refill: MEM_data_line<=mem_rline, MEM_mem_valid=1 next cycle.
    - WB: free the buffer; no cache response.
  - Then go to RECOVER.
- RECOVER: spend one cycle ignoring all requests, so a requester can drop its level request, then return to IDLE.
  - The refill data output holds its value until the next response to the same cache.
- Latency: a request seen in IDLE at cycle t gives mem_req at t+1. A mem_valid at cycle u gives the valid pulse at u+1. The minimum gap between consecutive grants is 2 cycles after mem_valid.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each D-side grant (WB or D-refill) made while Ic_mem_req=1.
  - Clears on an I-refill grant and whenever Ic_mem_req=0 in IDLE.
- Ordering: a buffered write-back always issues before any refill granted after its capture. This guarantees read-after-write on the same line for both caches.
- mem_valid outside WAIT is ignored; this includes a stale completion after reset.
- Reset asserted mid-transaction abandons it; requesters must re-request.

Decomposition:
- Shared package holds:
  - Owner encoding constants OWN_NONE/OWN_WB/OWN_D/OWN_I.
  - The FSM state typedef (IDLE, ISSUE, WAIT, RECOVER).
  - Default ADDR_W/LINE_W.
- One natural sub-module, wb_line_buffer: a one-entry buffer with capture, ready and free.
- Arbitration, FSM and routing stay in mem_arbiter.

Test Plan:
- Single I refill: Ic_mem_req=1, addr 0x0012, memory latency 3. Expect mem_req at t+1 with mem_we=0 and mem_addr=0x0012. Expect F_mem_valid pulse 1 cycle after mem_valid with F_mem_inst = returned line. Expect MEM_mem_valid to stay 0.
- Simultaneous Ic and Dc requests with the buffer empty: the D refill is granted first (arb_owner=2), and the I refill is granted after RECOVER (arb_owner=3).
- Write-back then refill of the same line:
  - Stimulus: Dc_wb_we pulse, addr 0x0040, line 0xA5..A5, with Dc_mem_req for 0x0040 one cycle later.
  - Expect a write issues first, then the read.
  - Expect MEM_data_line = 0xA5..A5 from the memory model.
  - Expect Dc_wb_ready low from capture until the cycle after the write's mem_valid.
- Starvation: hold Ic_mem_req high with continuous D requests and STARVE_LIMIT=4. Expect the 5th grant to go to the I side, with the counter cleared afterwards.
- Reset mid-WAIT: assert rst=0 during an I refill. Expect all outputs at reset values immediately and Dc_wb_ready=1. A stray mem_valid after release must produce no F_mem_valid pulse.
- Protocol error: a second Dc_wb_we while Dc_wb_ready=0 leaves buffer contents unchanged, and only the first line is written to memory.
